sevseg_scan_driver: RTL

Parametrised, time-multiplexed hex driver for a bank of common-anode seven-segment digits. It generalises the team's single-digit decoder in three ways: DIGITS-wide operation, a programmable refresh prescaler, and a per-digit decimal point. It adds a double-buffered value load, so updates never tear mid-frame. It sits between the counter/datapath logic and the board display pins, and replaces fixed-enable single-digit decoding.

---
 rtl/sevseg_scan_driver_if.sv | 37 +++
 rtl/sevseg_scan_driver.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sevseg_scan_driver_if.sv
// ---------------------------------------------------------------------------
// sevseg_scan_driver_if
// Bundle of the value-load and display-pin signals of sevseg_scan_driver.
//   load       : single-cycle strobe capturing value/dp_in into the shadow
//   value      : 4*DIGITS hex nibbles, nibble k -> digit k (0 = rightmost)
//   dp_in      : per-digit decimal-point request, 1 = lit
//   blank      : level, 1 forces every digit dark
//   seg        : {g,f,e,d,c,b,a}
//   dp         : decimal point of the active digit
//   an         : digit enables
//   frame_done : one-cycle pulse on scan wrap
//   pending    : a loaded value waits for the frame boundary
// master = value source / display consumer, slave = the driver itself.
// ---------------------------------------------------------------------------
interface sevseg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  blank;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     an;
    logic                  frame_done;
    logic                  pending;

    modport master (
        output load, value, dp_in, blank,
        input  seg, dp, an, frame_done, pending
    );

    modport slave (
        input  load, value, dp_in, blank,
        output seg, dp, an, frame_done, pending
    );
endinterface

// File: rtl/sevseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sevseg_scan_driver
// Time-multiplexed hex driver for DIGITS common-anode seven-segment digits
// with a programmable per-digit slot length, per-digit decimal point and a
// double-buffered value load that only takes effect at frame boundaries.
//
// Parameters
//   DIGITS     : number of multiplexed digits (1..8)
//   TICK_DIV   : clock cycles per digit slot (>= 2)
//   ACTIVE_LOW : 1 = seg/dp/an active-low, 0 = all three active-high
// Ports
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : sevseg_scan_driver_if.slave (load/value/dp_in/blank in,
//           seg/dp/an/frame_done/pending out, all outputs registered)
// Build option
//   SEVSEG_LZB_EN : when defined, leading-zero blanking is enabled
//                   (digit 0 and digits with their dp set are never blanked).
// ---------------------------------------------------------------------------
module sevseg_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int TICK_DIV   = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    sevseg_scan_driver_if.slave  bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(TICK_DIV);

    localparam logic [6:0]        SEG_OFF = ACTIVE_LOW ? 7'h7f : 7'h00;
    localparam logic              DP_OFF  = ACTIVE_LOW ? 1'b1  : 1'b0;
    localparam logic [DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? '1    : '0;

    // Table is in lit-low form ({g..a}); returned value is 1 = lit segment.
    function automatic logic [6:0] hex_lit(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return ~pat;
    endfunction

    logic [PRE_W-1:0]    prescaler;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] shadow_val;
    logic [DIGITS-1:0]   shadow_dp;
    logic [4*DIGITS-1:0] disp_val;
    logic [DIGITS-1:0]   disp_dp;
    logic                pending_r;
    logic                frame_done_r;

    logic [6:0]          seg_p1;
    logic                dp_p1;
    logic [DIGITS-1:0]   an_p1;

    logic                tick;
    logic                wrap;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic [DIGITS-1:0]   an_hot;
    logic                suppress;
    logic                dark;
    logic [6:0]          seg_nxt;
    logic                dp_nxt;
    logic [DIGITS-1:0]   an_nxt;
`ifdef SEVSEG_LZB_EN
    logic [IDX_W-1:0]    msd;
`endif

    assign tick = (prescaler == PRE_W'(TICK_DIV - 1));
    assign wrap = tick && (idx == IDX_W'(DIGITS - 1));

    // ---- stage p0: select active digit and decode (combinational) ----
    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        an_hot  = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib   = disp_val[4*k +: 4];
                cur_dp    = disp_dp[k];
                an_hot[k] = 1'b1;
            end
        end
`ifdef SEVSEG_LZB_EN
        // Highest nonzero nibble; an all-zero register leaves msd at 0 so
        // digit 0 always remains visible.
        msd = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (disp_val[4*k +: 4] != 4'h0) msd = IDX_W'(k);
        end
        suppress = (idx > msd) && !cur_dp;
`else
        suppress = 1'b0;
`endif
        dark = bus.blank || suppress;
        if (dark) begin
            seg_nxt = SEG_OFF;
            dp_nxt  = DP_OFF;
            an_nxt  = AN_OFF;
        end else begin
            seg_nxt = ACTIVE_LOW ? ~hex_lit(cur_nib) : hex_lit(cur_nib);
            dp_nxt  = ACTIVE_LOW ? ~cur_dp : cur_dp;
            an_nxt  = ACTIVE_LOW ? ~an_hot : an_hot;
        end
    end

    // ---- stage p1: scan state, buffering and output registers ----
    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler    <= '0;
            idx          <= '0;
            shadow_val   <= '0;
            shadow_dp    <= '0;
            disp_val     <= '0;
            disp_dp      <= '0;
            pending_r    <= 1'b0;
            frame_done_r <= 1'b0;
            seg_p1       <= SEG_OFF;
            dp_p1        <= DP_OFF;
            an_p1        <= AN_OFF;
        end else begin
            prescaler    <= tick ? '0 : prescaler + PRE_W'(1);
            if (tick) idx <= wrap ? '0 : idx + IDX_W'(1);
            frame_done_r <= wrap;
            // Copy uses the shadow as it stood before this edge; a load on
            // the same edge lands in the shadow and re-arms pending below.
            if (wrap && pending_r) begin
                disp_val  <= shadow_val;
                disp_dp   <= shadow_dp;
                pending_r <= 1'b0;
            end
            if (bus.load) begin
                shadow_val <= bus.value;
                shadow_dp  <= bus.dp_in;
                pending_r  <= 1'b1;
            end
            seg_p1 <= seg_nxt;
            dp_p1  <= dp_nxt;
            an_p1  <= an_nxt;
        end
    end

    assign bus.seg        = seg_p1;
    assign bus.dp         = dp_p1;
    assign bus.an         = an_p1;
    assign bus.frame_done = frame_done_r;
    assign bus.pending    = pending_r;

endmodule
